// File: rtl/led_pattern_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Default pattern length and the SOS boot pattern live here so every channel agrees on them.
package led_pattern_seq_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} chan_st_t;

   localparam int DEF_PAT_LEN = 32;
   localparam int IDX_W       = $clog2(DEF_PAT_LEN);
   localparam int LEN_W       = $clog2(DEF_PAT_LEN + 1);

   // SOS: short-short-short, long-long-long, short-short-short, LSB plays first
   localparam logic [31:0] SOS_PATTERN = 32'b101010001110111011100010101;

   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// One sequencer channel: holds a pattern and steps through it LSB first,
// each bit held div_r+1 cycles, looping or stopping with a done pulse.
module led_pattern_chan
   import led_pattern_seq_pkg::*;
#(
   parameter int                 PAT_LEN      = DEF_PAT_LEN,
   parameter int                 DIV_W        = 24,
   parameter int                 BOOT_EN      = 0,
   parameter logic [PAT_LEN-1:0] BOOT_PATTERN = PAT_LEN'(SOS_PATTERN),
   parameter int                 BOOT_LEN     = 32,
   parameter int                 BOOT_DIV     = 2097151,
   parameter int                 IDLE_LEVEL   = 0,
   localparam int                IW           = max1($clog2(PAT_LEN)),
   localparam int                LW           = $clog2(PAT_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic [LW-1:0]      len,
   input  logic [DIV_W-1:0]   div,
   input  logic               oneshot,
   output logic               led,
   output logic               busy,
   output logic               done
);

   localparam chan_st_t RST_ST = (BOOT_EN != 0) ? RUN : IDLE;

   chan_st_t           st, st_n;
   logic [PAT_LEN-1:0] pat_r, pat_n;
   logic [LW-1:0]      len_r, len_n, len_c;
   logic [DIV_W-1:0]   div_r, div_n, cnt, cnt_n;
   logic [IW-1:0]      idx, idx_n;
   logic               os_r, os_n, done_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st     <= RST_ST;
         pat_r  <= (BOOT_EN != 0) ? BOOT_PATTERN : '0;
         len_r  <= (BOOT_EN != 0) ? LW'(BOOT_LEN) : '0;
         div_r  <= (BOOT_EN != 0) ? DIV_W'(BOOT_DIV) : '0;
         os_r   <= 1'b0;
         idx    <= '0;
         cnt    <= '0;
         done   <= 1'b0;
      end else begin
         st     <= st_n;
         pat_r  <= pat_n;
         len_r  <= len_n;
         div_r  <= div_n;
         os_r   <= os_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         done   <= done_n;
      end
   end

   // A load always overrides the step logic, so a coincident one-shot end never pulses done
   always_comb begin
      st_n   = st;
      pat_n  = pat_r;
      len_n  = len_r;
      div_n  = div_r;
      os_n   = os_r;
      idx_n  = idx;
      cnt_n  = cnt;
      done_n = 1'b0;
      len_c  = (len > LW'(PAT_LEN)) ? LW'(PAT_LEN) : len;
      if (ld) begin
         if (len == '0) begin
            st_n = IDLE;
         end else begin
            st_n  = RUN;
            pat_n = pattern;
            len_n = len_c;
            div_n = div;
            os_n  = oneshot;
            idx_n = '0;
            cnt_n = '0;
         end
      end else if (st == RUN) begin
         if (cnt != div_r) begin
            cnt_n = cnt + DIV_W'(1);
         end else begin
            cnt_n = '0;
            if (LW'(idx) != len_r - LW'(1)) begin
               idx_n = idx + IW'(1);
            end else if (!os_r) begin
               idx_n = '0;
            end else begin
               st_n   = IDLE;
               done_n = 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy = (st == RUN);
      led  = (st == RUN) ? pat_r[idx] : (IDLE_LEVEL != 0);
   end

endmodule

// File: rtl/led_pattern_seq.sv
// Multi-channel LED pattern sequencer: routes load requests to channels;
// only channel 0 may auto-run the boot pattern out of reset.
module led_pattern_seq
   import led_pattern_seq_pkg::*;
#(
   parameter int                 CHANNELS     = 1,
   parameter int                 PAT_LEN      = DEF_PAT_LEN,
   parameter int                 DIV_W        = 24,
   parameter int                 BOOT_EN      = 1,
   parameter logic [PAT_LEN-1:0] BOOT_PATTERN = PAT_LEN'(SOS_PATTERN),
   parameter int                 BOOT_LEN     = 32,
   parameter int                 BOOT_DIV     = 2097151,
   parameter int                 IDLE_LEVEL   = 0,
   localparam int                CW           = max1($clog2(CHANNELS)),
   localparam int                LW           = $clog2(PAT_LEN + 1)
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [CW-1:0]       load_chan,
   input  logic [PAT_LEN-1:0]  load_pattern,
   input  logic [LW-1:0]       load_len,
   input  logic [DIV_W-1:0]    load_div,
   input  logic                load_oneshot,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done
);

   logic accept;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) load_ready <= 1'b0;
      else       load_ready <= 1'b1;
   end

   assign accept = load_valid && load_ready;

   // Out-of-range channel numbers match no instance and are silently dropped
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      led_pattern_chan #(
         .PAT_LEN     (PAT_LEN),
         .DIV_W       (DIV_W),
         .BOOT_EN     ((c == 0) ? BOOT_EN : 0),
         .BOOT_PATTERN(BOOT_PATTERN),
         .BOOT_LEN    (BOOT_LEN),
         .BOOT_DIV    (BOOT_DIV),
         .IDLE_LEVEL  (IDLE_LEVEL)
      ) u_chan (
         .clk    (CLK),
         .reset  (reset),
         .ld     (accept && (load_chan == CW'(c))),
         .pattern(load_pattern),
         .len    (load_len),
         .div    (load_div),
         .oneshot(load_oneshot),
         .led    (led[c]),
         .busy   (busy[c]),
         .done   (done[c])
      );
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: boot pattern, vector table on channel 1,
// then hand-written reset, clamp, out-of-range and multi-channel sequences.
module tb_led_pattern_seq;

   localparam int CH = 3;

   logic        CLK, reset, load_valid, load_ready, load_oneshot;
   logic [1:0]  load_chan;
   logic [31:0] load_pattern;
   logic [5:0]  load_len;
   logic [23:0] load_div;
   logic [CH-1:0] led, busy, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        v;
      logic [1:0]  c;
      logic [31:0] p;
      logic [5:0]  l;
      logic [23:0] d;
      logic        o;
      logic [2:0]  e;   // expected {led[1], busy[1], done[1]} after the edge
   } vec_t;

   vec_t tbl[24];

   led_pattern_seq #(
      .CHANNELS(CH), .PAT_LEN(32), .DIV_W(24), .BOOT_EN(1),
      .BOOT_LEN(32), .BOOT_DIV(3), .IDLE_LEVEL(0)
   ) dut (
      .CLK(CLK), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_chan(load_chan), .load_pattern(load_pattern), .load_len(load_len),
      .load_div(load_div), .load_oneshot(load_oneshot),
      .led(led), .busy(busy), .done(done)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] p,
                        input logic [5:0] l, input logic [23:0] d, input logic o);
      load_valid = v; load_chan = c; load_pattern = p;
      load_len = l; load_div = d; load_oneshot = o;
   endtask

   function automatic vec_t row(input logic v, input logic [1:0] c, input logic [31:0] p,
                                input logic [5:0] l, input logic [23:0] d, input logic o,
                                input logic [2:0] e);
      vec_t r;
      r.v = v; r.c = c; r.p = p; r.l = l; r.d = d; r.o = o; r.e = e;
      return r;
   endfunction

   initial begin
      logic [31:0] sos, pc, p0, p1;
      sos = 32'b101010001110111011100010101;

      // one-shot 1011, div 1
      tbl[0]  = row(1, 1, 32'hB, 4, 1, 1, 3'b110);
      tbl[1]  = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[2]  = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[3]  = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[4]  = row(0, 0, 0, 0, 0, 0, 3'b010);
      tbl[5]  = row(0, 0, 0, 0, 0, 0, 3'b010);
      tbl[6]  = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[7]  = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[8]  = row(0, 0, 0, 0, 0, 0, 3'b001);
      tbl[9]  = row(0, 0, 0, 0, 0, 0, 3'b000);
      // loop 01, div 0, then stop with len 0
      tbl[10] = row(1, 1, 32'h1, 2, 0, 0, 3'b110);
      tbl[11] = row(0, 0, 0, 0, 0, 0, 3'b010);
      tbl[12] = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[13] = row(0, 0, 0, 0, 0, 0, 3'b010);
      tbl[14] = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[15] = row(1, 1, 32'h3, 0, 0, 0, 3'b000);
      tbl[16] = row(0, 0, 0, 0, 0, 0, 3'b000);
      // load lands on the final step-end of a one-shot
      tbl[17] = row(1, 1, 32'h2, 2, 0, 1, 3'b010);
      tbl[18] = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[19] = row(1, 1, 32'h1, 1, 2, 1, 3'b110);
      tbl[20] = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[21] = row(0, 0, 0, 0, 0, 0, 3'b110);
      tbl[22] = row(0, 0, 0, 0, 0, 0, 3'b001);
      tbl[23] = row(0, 0, 0, 0, 0, 0, 3'b000);

      drive(0, 0, 0, 0, 0, 0);
      reset = 1;
      #2;
      chk("reset_led", 32'(led), 32'b001);
      chk("reset_busy", 32'(busy), 32'b001);
      chk("reset_done", 32'(done), 32'b000);
      chk("reset_ready", 32'(load_ready), 32'b0);
      step();
      step();
      chk("reset_hold_led", 32'(led), 32'b001);
      reset = 0;
      #1;

      // boot pattern, 4 cycles per bit, wraps after 128 cycles
      for (int k = 0; k < 136; k++) begin
         if (k == 0) chk("ready_before_edge", 32'(load_ready), 32'b0);
         if (k == 1) chk("ready_after_edge", 32'(load_ready), 32'b1);
         chk($sformatf("boot_k%0d", k), {29'b0, led[0], busy[0], done[0]},
             {29'b0, sos[(k / 4) % 32], 1'b1, 1'b0});
         step();
      end

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].l, tbl[i].d, tbl[i].o);
         step();
         chk($sformatf("tbl_row%0d", i), {29'b0, led[1], busy[1], done[1]}, {29'b0, tbl[i].e});
      end
      drive(0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of a channel-1 loop
      drive(1, 1, 32'h1, 2, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      step();
      #2 reset = 1;
      #1;
      chk("midreset_ch1", {30'b0, led[1], busy[1]}, 32'b00);
      chk("midreset_ch0", {30'b0, led[0], busy[0]}, 32'b11);
      chk("midreset_ready", 32'(load_ready), 32'b0);
      step();
      reset = 0;
      step();

      // out-of-range channel is dropped
      drive(1, 3, 32'hFFFF_FFFF, 5, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("badchan_k%0d", k), {28'b0, led[2:1], busy[2:1]}, 32'b0);
         step();
      end

      // length above PAT_LEN clamps to 32 bits
      pc = 32'h8000_0001;
      drive(1, 1, pc, 40, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k <= 32; k++) begin
         chk($sformatf("clamp_k%0d", k), {29'b0, led[1], busy[1], done[1]},
             (k < 32) ? {29'b0, pc[k], 2'b10} : 32'b001);
         step();
      end

      // chan0 preempts the boot pattern, chan1 loaded the next cycle
      p0 = 32'b0110;
      p1 = 32'b10;
      drive(1, 0, p0, 4, 2, 0);
      step();
      chk("preempt_ch0", {29'b0, led[0], busy[0], done[0]}, 32'b010);
      drive(1, 1, p1, 2, 1, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      for (int m = 0; m < 24; m++) begin
         chk($sformatf("dual_m%0d", m), {27'b0, led[1:0], busy[1:0], done[0] | done[1]},
             {27'b0, p1[(m / 2) % 2], p0[((m + 1) / 3) % 4], 2'b11, 1'b0});
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
